// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-4 demux
package demux_pkg;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux_sat_cnt.sv
// rtl/demux_sat_cnt.sv - 8-bit saturating hit counter with async active-high reset
module demux_sat_cnt
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  cnt_t r_cnt;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/demux1_4_if_top.sv
// rtl/demux1_4_if_top.sv - registered 1-to-4 demux; DEMUX_HIT_CNT_EN adds per-lane hit counters
module demux1_4_if_top
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       X,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] Y
`ifdef DEMUX_HIT_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  hit_cnt
`endif
);

  logic [N_OUT*DATA_W-1:0] w_y_next;
  logic [N_OUT*DATA_W-1:0] r_y;

  // Final else also absorbs an unknown sel, steering X to lane 3.
  always_comb begin
    w_y_next = '0;
    if (sel == 2'd0) begin
      w_y_next[0*DATA_W +: DATA_W] = X;
    end else if (sel == 2'd1) begin
      w_y_next[1*DATA_W +: DATA_W] = X;
    end else if (sel == 2'd2) begin
      w_y_next[2*DATA_W +: DATA_W] = X;
    end else begin
      w_y_next[3*DATA_W +: DATA_W] = X;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= '0;
    end else begin
      r_y <= w_y_next;
    end
  end

  assign Y = r_y;

`ifdef DEMUX_HIT_CNT_EN
  // A lane is hit exactly when its next value is nonzero.
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic w_hit;
    assign w_hit = |w_y_next[k*DATA_W +: DATA_W];

    demux_sat_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_hit),
      .o_cnt (hit_cnt[k*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_demux1_4_if_top.sv
// tb/tb_demux1_4_if_top.sv - directed self-checking bench for demux1_4_if_top
module tb_demux1_4_if_top;

  logic       clk;
  logic       rst;
  logic [0:0] X;
  logic [1:0] sel;
  logic [3:0] Y;
`ifdef DEMUX_HIT_CNT_EN
  logic [31:0] hit_cnt;
`endif

  int total = 0;
  int bad   = 0;

  demux1_4_if_top #(.DATA_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .X   (X),
    .sel (sel),
    .Y   (Y)
`ifdef DEMUX_HIT_CNT_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_y;

  initial begin
    rst = 1'b1;
    X   = 1'b1;
    sel = 2'd2;
    #2;
    check("reset_async", {28'd0, Y}, 32'h0);
    tick();
    check("reset_hold", {28'd0, Y}, 32'h0);
    rst = 1'b0;
    tick();
    check("release_first", {28'd0, Y}, 32'h4);

    X = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check("x0_sweep", {28'd0, Y}, 32'h0);
    end

    X = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check("x1_sweep", {28'd0, Y}, 32'h1 << s);
    end

    sel = 2'd1;
    tick();
    check("lat_pre", {28'd0, Y}, 32'h2);
    sel = 2'd3;
    #3;
    check("lat_midcycle", {28'd0, Y}, 32'h2);
    tick();
    check("lat_after", {28'd0, Y}, 32'h8);

    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", {28'd0, Y}, 32'h0);
    tick();
    check("mid_rst_hold", {28'd0, Y}, 32'h0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_noedge", {28'd0, Y}, 32'h0);
    tick();
    check("mid_rst_after_edge", {28'd0, Y}, 32'h8);

    // A two-state simulator may resolve the unknown select to a real value.
    X   = 1'b1;
    sel = 2'bxx;
    exp_y = $isunknown(sel) ? 4'b1000 : (4'b0001 << sel);
    tick();
    check("sel_unknown", {28'd0, Y}, {28'd0, exp_y});

    for (int i = 0; i < 40; i++) begin
      X   = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      exp_y = X ? (4'b0001 << sel) : 4'b0000;
      tick();
      check("rand_y", {28'd0, Y}, {28'd0, exp_y});
      check("rand_onehot0", {31'd0, $onehot0(Y)}, 32'h1);
    end

`ifdef DEMUX_HIT_CNT_EN
    #2;
    rst = 1'b1;
    #1;
    check("cnt_rst", hit_cnt, 32'h0);
    tick();
    rst = 1'b0;
    X   = 1'b1;
    sel = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    check("cnt_three", hit_cnt, 32'h0000_0300);
    X = 1'b0;
    tick();
    check("cnt_x0_nohit", hit_cnt, 32'h0000_0300);
    X = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("cnt_saturate", hit_cnt, 32'h0000_FF00);
    #2;
    rst = 1'b1;
    #1;
    check("cnt_rst_after_sat", hit_cnt, 32'h0);
    tick();
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
